fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 180 ++++++++++++++++++
 tb/tb_fifo_rd_stream.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream
//
// Read side of an asynchronous FIFO. It brings the Gray-coded write pointer
// into the read clock domain, keeps the read pointer (binary and Gray), and
// fetches words from a synchronous SRAM. Each word leaves on a
// valid/ready stream port.
//
// The SRAM has one cycle of read latency. A two-entry output buffer absorbs
// that latency, so the stream can run at one word per cycle. It also holds
// its head word steady while the consumer stalls.
//
// Parameters
//   ASIZE        address width; storage depth is 2**ASIZE words
//   DSIZE        data word width
//   SYNC_STAGES  write-pointer synchronizer depth (2..4)
//   AE_LEVEL     almost-empty threshold in words
//
// Ports
//   rclk           read-domain clock
//   rrst_n         asynchronous active-low reset
//   wptr_async     Gray write pointer from the write clock domain
//   rptr           Gray read pointer (registered) for the write clock domain
//   raddr          SRAM read address (low ASIZE bits of binary read pointer)
//   ren            SRAM read enable
//   rdata_mem      SRAM read data, valid the cycle after ren
//   m_valid        output word valid
//   m_ready        downstream accepts the word
//   m_data         output word (head of the output buffer)
//   rlevel         words in storage not yet read from the SRAM
//   rempty         storage empty (registered)
//   ralmost_empty  rlevel <= AE_LEVEL
// ---------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int ASIZE       = 4,
    parameter int DSIZE       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AE_LEVEL    = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   wptr_async,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             ren,
    input  logic [DSIZE-1:0] rdata_mem,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [ASIZE:0]   rlevel,
    output logic             rempty,
    output logic             ralmost_empty
);

    // Threshold resized to the level width so the compare is width-exact.
    localparam logic [ASIZE:0] AE_LEVEL_W = AE_LEVEL[ASIZE:0];

    // -----------------------------------------------------------------------
    // Write-pointer synchronizer
    // -----------------------------------------------------------------------
    logic [ASIZE:0] sync_q [SYNC_STAGES];
    logic [ASIZE:0] rs_wptr;
    logic [ASIZE:0] rs_wbin;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wptr_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign rs_wptr = sync_q[SYNC_STAGES-1];

    // Gray to binary: bit i is the XOR of all Gray bits at or above i.
    // This is used only for the fill level.
    for (genvar gi = 0; gi <= ASIZE; gi++) begin : g_wbin
        assign rs_wbin[gi] = ^rs_wptr[ASIZE:gi];
    end

    // -----------------------------------------------------------------------
    // Read pointer and empty flag
    // -----------------------------------------------------------------------
    logic [ASIZE:0] rbin_q;
    logic [ASIZE:0] rbin_d;
    logic [ASIZE:0] rptr_q;
    logic [ASIZE:0] rgray_d;
    logic           rempty_q;
    logic           rempty_d;

    assign rbin_d   = rbin_q + {{ASIZE{1'b0}}, ren};
    assign rgray_d  = rbin_d ^ (rbin_d >> 1);
    // Compare the next read pointer with the synchronized write pointer.
    // As a result, rempty is already high in the cycle after the last word
    // is fetched, and ren can never fetch past the write pointer.
    assign rempty_d = (rgray_d == rs_wptr);

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rgray_d;
            rempty_q <= rempty_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output buffer: two entries; entry 0 is always the head
    // -----------------------------------------------------------------------
    logic             inflight_q;
    logic [1:0]       buf_cnt_q;
    logic [1:0]       buf_cnt_d;
    logic [DSIZE-1:0] buf_q [2];
    logic [DSIZE-1:0] buf_d [2];
    logic             pop;
    logic [2:0]       occ_after_pop;
    logic             tail_idx;

    assign pop = m_valid & m_ready;

    // Occupancy after this edge, counting the word coming back from the
    // SRAM. A new read is issued only if that still leaves a free slot.
    // Because of this, buf_cnt + inflight never exceeds 2.
    assign occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign ren           = ~rempty_q & (occ_after_pop < 3'd2);

    // Slot for the returning word: buf_cnt - pop. That value is only 0 or 1
    // whenever a word is in flight, so one bit is enough. (For the same
    // reason, buf_cnt=2 with no pop cannot happen here.)
    assign tail_idx = buf_cnt_q[0] ^ pop;

    always_comb begin
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        // The pop shift goes first, so a capture on the same edge lands
        // behind the surviving entry.
        if (pop) begin
            buf_d[0] = buf_q[1];
        end
        if (inflight_q) begin
            buf_d[tail_idx] = rdata_mem;
        end
        buf_cnt_d = occ_after_pop[1:0];
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_q <= 1'b0;
            buf_cnt_q  <= '0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            inflight_q <= ren;
            buf_cnt_q  <= buf_cnt_d;
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rptr          = rptr_q;
    assign raddr         = rbin_q[ASIZE-1:0];
    assign rempty        = rempty_q;
    assign m_valid       = (buf_cnt_q != 2'd0);
    assign m_data        = buf_q[0];
    // Modulo subtraction. This stays correct across the pointer MSB wrap.
    assign rlevel        = rs_wbin - rbin_q;
    assign ralmost_empty = (rlevel <= AE_LEVEL_W);

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
    localparam int ASIZE = 4;
    localparam int DSIZE = 8;
    localparam int SYNC  = 2;
    localparam int AE    = 2;
    localparam int DEPTH = 1 << ASIZE;

    logic             rclk = 1'b0;
    logic             rrst_n = 1'b0;
    logic [ASIZE:0]   wptr_async = '0;
    logic [ASIZE:0]   rptr;
    logic [ASIZE-1:0] raddr;
    logic             ren;
    logic [DSIZE-1:0] rdata_mem = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [DSIZE-1:0] m_data;
    logic [ASIZE:0]   rlevel;
    logic             rempty;
    logic             ralmost_empty;

    fifo_rd_stream #(
        .ASIZE(ASIZE), .DSIZE(DSIZE), .SYNC_STAGES(SYNC), .AE_LEVEL(AE)
    ) dut (
        .rclk(rclk), .rrst_n(rrst_n), .wptr_async(wptr_async), .rptr(rptr),
        .raddr(raddr), .ren(ren), .rdata_mem(rdata_mem), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .rlevel(rlevel), .rempty(rempty),
        .ralmost_empty(ralmost_empty)
    );

    always #5 rclk = ~rclk;

    // Behavioural SRAM with one cycle of read latency.
    logic [DSIZE-1:0] mem [DEPTH];
    always @(posedge rclk) begin
        if (ren) rdata_mem <= mem[raddr];
    end

    int               vectors = 0;
    int               miscompares = 0;
    logic [ASIZE:0]   wbin = '0;
    logic [DSIZE-1:0] exp_q [$];

    function automatic logic [ASIZE:0] to_gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ASIZE:0] from_gray(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Words written but not yet read out of the SRAM (writer-side flow control).
    function automatic int stored();
        logic [ASIZE:0] diff;
        diff = wbin - from_gray(rptr);
        return int'(diff);
    endfunction

    task automatic push_word(input logic [DSIZE-1:0] d);
        mem[wbin[ASIZE-1:0]] = d;
        exp_q.push_back(d);
        wbin = wbin + 1'b1;
    endtask

    task automatic publish();
        wptr_async = to_gray(wbin);
    endtask

    task automatic to_drive();
        @(posedge rclk);
        #1;
    endtask

    task automatic test_reset();
        logic [27:0] obs, expv;
        rrst_n = 1'b0;
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        obs  = {m_valid, ren, rempty, ralmost_empty, rptr, raddr, rlevel, m_data};
        expv = {1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 4'd0, 5'd0, 8'd0};
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL reset_values: got %h expected %h", obs, expv);
        end
        to_drive();
        rrst_n = 1'b1;
    endtask

    task automatic test_single_word();
        logic [DSIZE-1:0] d;
        logic [1:0] obs, expv;
        to_drive();
        m_ready = 1'b1;
        push_word(8'(($urandom % 255) + 1));
        publish();
        for (int n = 1; n <= 8; n++) begin
            @(posedge rclk);
            @(negedge rclk);
            obs  = {m_valid, ren};
            expv = {1'(n == SYNC + 3), 1'(n == SYNC + 1)};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL single_latency edge %0d: got valid,ren=%b expected %b", n, obs, expv);
            end
            if (n == SYNC + 3 && exp_q.size() > 0) begin
                d = exp_q.pop_front();
                vectors++;
                if (m_data !== d) begin
                    miscompares++;
                    $display("FAIL single_data: got %h expected %h", m_data, d);
                end
            end
        end
        vectors++;
        if (rempty !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_drain: got rempty=%b left=%0d expected 1 and 0", rempty, exp_q.size());
        end
    endtask

    task automatic test_burst16();
        int k, rl;
        logic [DSIZE-1:0] d;
        logic [6:0] obs, expv;
        to_drive();
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_word(8'($urandom));
        publish();
        for (int n = 1; n <= 24; n++) begin
            @(posedge rclk);
            @(negedge rclk);
            k = n - SYNC;
            // rlevel counts the whole burst once it is synchronized. Reads
            // start one edge later, then run one per edge.
            if (k < 0)       rl = 0;
            else if (k <= 1) rl = DEPTH;
            else             rl = (DEPTH - (k - 1) > 0) ? DEPTH - (k - 1) : 0;
            obs  = {rlevel, ralmost_empty, m_valid};
            expv = {5'(rl), 1'(rl <= AE), 1'(k >= 3 && k <= DEPTH + 2)};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL burst_level edge %0d: got lvl,ae,valid=%h expected %h", n, obs, expv);
            end
            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL burst_order: got extra word %h expected none", m_data);
                end else begin
                    d = exp_q.pop_front();
                    if (m_data !== d) begin
                        miscompares++;
                        $display("FAIL burst_order: got %h expected %h", m_data, d);
                    end
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL burst_count: got %0d words left expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall_fill();
        int ren_cnt;
        logic [DSIZE-1:0] d;
        logic [15:0] obs, expv;
        to_drive();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        publish();
        ren_cnt = 0;
        for (int n = 1; n <= 15; n++) begin
            @(posedge rclk);
            @(negedge rclk);
            if (ren) ren_cnt++;
        end
        obs  = {3'(ren_cnt), rlevel, m_valid, ralmost_empty, 6'd0};
        expv = {3'd2, 5'd3, 1'b1, 1'b0, 6'd0};
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL stall_fill: got ren_cnt,lvl,valid,ae=%h expected %h", obs, expv);
        end
        vectors++;
        if (m_data !== exp_q[0]) begin
            miscompares++;
            $display("FAIL stall_head: got %h expected %h", m_data, exp_q[0]);
        end
        to_drive();
        m_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge rclk);
            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stall_order: got extra word %h expected none", m_data);
                end else begin
                    d = exp_q.pop_front();
                    if (m_data !== d) begin
                        miscompares++;
                        $display("FAIL stall_order: got %h expected %h", m_data, d);
                    end
                end
            end
            @(posedge rclk);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_drain: got %0d words left expected 0", exp_q.size());
        end
    endtask

    task automatic test_wrap();
        int written;
        logic ptr_wrap, addr_wrap;
        logic [ASIZE:0] prev_rptr, rb;
        logic [ASIZE-1:0] prev_raddr;
        logic [DSIZE-1:0] d;
        written = 0; ptr_wrap = 1'b0; addr_wrap = 1'b0;
        prev_rptr = rptr; prev_raddr = raddr;
        for (int c = 0; c < 400 && (written < 40 || exp_q.size() > 0); c++) begin
            to_drive();
            m_ready = 1'b1;
            if (written < 40 && stored() < DEPTH) begin
                push_word(8'($urandom));
                publish();
                written++;
            end
            @(negedge rclk);
            vectors++;
            if ($countones(rptr ^ prev_rptr) > 1) begin
                miscompares++;
                $display("FAIL wrap_gray: got %b after %b expected one-bit step", rptr, prev_rptr);
            end
            rb = from_gray(rptr);
            vectors++;
            if (raddr !== rb[ASIZE-1:0]) begin
                miscompares++;
                $display("FAIL wrap_raddr: got %h expected %h", raddr, rb[ASIZE-1:0]);
            end
            if (prev_rptr == to_gray(5'd31) && rptr == 5'd0) ptr_wrap = 1'b1;
            if (prev_raddr == 4'd15 && raddr == 4'd0) addr_wrap = 1'b1;
            prev_rptr = rptr; prev_raddr = raddr;
            if (m_valid && m_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL wrap_order: got extra word %h expected none", m_data);
                end else begin
                    d = exp_q.pop_front();
                    if (m_data !== d) begin
                        miscompares++;
                        $display("FAIL wrap_order: got %h expected %h", m_data, d);
                    end
                end
            end
        end
        vectors++;
        if ({ptr_wrap, addr_wrap} !== 2'b11 || exp_q.size() != 0 || written != 40) begin
            miscompares++;
            $display("FAIL wrap_done: got ptr_wrap=%b addr_wrap=%b left=%0d written=%0d expected 1 1 0 40",
                     ptr_wrap, addr_wrap, exp_q.size(), written);
        end
    endtask

    task automatic test_random();
        int written, ren_total, pop_total;
        logic prev_stall;
        logic [DSIZE-1:0] prev_data, d;
        written = 0; ren_total = 0; pop_total = 0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 6000 && (written < 1000 || exp_q.size() > 0); c++) begin
            to_drive();
            m_ready = 1'($urandom_range(0, 1));
            if (written < 1000 && $urandom_range(0, 1) == 1 && stored() < DEPTH) begin
                push_word(8'($urandom));
                publish();
                written++;
            end
            @(negedge rclk);
            if (prev_stall) begin
                vectors++;
                if ({m_valid, m_data} !== {1'b1, prev_data}) begin
                    miscompares++;
                    $display("FAIL rand_stable: got valid,data=%b,%h expected 1,%h", m_valid, m_data, prev_data);
                end
            end
            if (ren) ren_total++;
            if (m_valid && m_ready) begin
                pop_total++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL rand_order: got extra word %h expected none", m_data);
                end else begin
                    d = exp_q.pop_front();
                    if (m_data !== d) begin
                        miscompares++;
                        $display("FAIL rand_order: got %h expected %h", m_data, d);
                    end
                end
            end
            vectors++;
            if (ren_total - pop_total > 2) begin
                miscompares++;
                $display("FAIL rand_occupancy: got %0d words held expected at most 2", ren_total - pop_total);
            end
            prev_stall = m_valid & ~m_ready;
            prev_data  = m_data;
        end
        vectors++;
        if (exp_q.size() != 0 || written != 1000) begin
            miscompares++;
            $display("FAIL rand_complete: got written=%0d left=%0d expected 1000 and 0", written, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [DSIZE-1:0] d;
        logic [20:0] obs, expv;
        to_drive();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_word(8'($urandom));
        publish();
        repeat (12) @(posedge rclk);
        @(negedge rclk);
        #2;
        rrst_n = 1'b0;
        #1;
        obs  = {m_valid, rempty, ren, m_data, rptr, rlevel};
        expv = {1'b0, 1'b1, 1'b0, 8'd0, 5'd0, 5'd0};
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL midreset_async: got %h expected %h", obs, expv);
        end
        wbin = '0;
        wptr_async = '0;
        exp_q.delete();
        repeat (2) @(posedge rclk);
        #1;
        rrst_n = 1'b1;
        to_drive();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(8'($urandom));
        publish();
        for (int n = 1; n <= 15; n++) begin
            @(posedge rclk);
            @(negedge rclk);
            vectors++;
            if (m_valid !== 1'(n >= SYNC + 3 && n <= SYNC + 5)) begin
                miscompares++;
                $display("FAIL midreset_valid edge %0d: got %b expected %b", n, m_valid, 1'(n >= SYNC + 3 && n <= SYNC + 5));
            end
            if (m_valid && m_ready && exp_q.size() > 0) begin
                d = exp_q.pop_front();
                vectors++;
                if (m_data !== d) begin
                    miscompares++;
                    $display("FAIL midreset_data: got %h expected %h", m_data, d);
                end
            end
        end
        vectors++;
        if (exp_q.size() != 0 || rempty !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_drain: got left=%0d rempty=%b expected 0 and 1", exp_q.size(), rempty);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst16();
        test_stall_fill();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
